// File: rtl/axi_2_obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_2_obi_pkg
// Description : Shared types and constants for the AXI4-slave to OBI-master
//               bridge: FSM state encoding, AXI burst/response encodings and
//               the packed AXI request/response channel structs.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_2_obi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_ID_W   = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_DATA = 3'd4,
        WR_REQ  = 3'd5,
        WR_WAIT = 3'd6,
        WR_RESP = 3'd7
    } axi_2_obi_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ax_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_2_obi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_2_obi_resp_t;

endpackage
`default_nettype wire

// File: rtl/axi_2_obi_core_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Combinational AXI next-beat address. FIXED holds the address,
//               INCR (and WRAP, handled as INCR) adds 1 << size. The sum wraps
//               naturally modulo 2^ADDR_W.
// Ports       : i_addr  current beat address
//               i_size  AXI size (log2 bytes per beat)
//               i_burst AXI burst type
//               o_next_addr address of the following beat
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_2_obi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_step;

    assign w_step      = ADDR_W'(1) << i_size;
    assign o_next_addr = (i_burst == BURST_FIXED) ? i_addr : (i_addr + w_step);

endmodule
`default_nettype wire

// File: rtl/axi_2_obi_core.sv
`default_nettype none
// ============================================================================
// Module      : axi_2_obi_core
// Description : AXI4 slave to OBI master bridge. One AXI transaction and one
//               OBI transfer in flight at a time; each AXI beat becomes one
//               OBI request. Responses are always OKAY.
// Ports       : clk_i/srst_i  clock, synchronous active-high reset
//               axi_req_i     AXI aw/w/ar channels plus b_ready/r_ready
//               axi_resp_o    AXI ready signals plus b/r channels
//               addr_o/we_o/wdata_o/be_o/req_o  OBI request
//               gnt_i/rvalid_i/rdata_i          OBI grant and response
// Revision    : 1.0 - initial release
// ============================================================================
module axi_2_obi_core
    import axi_2_obi_pkg::*;
#(
    parameter int  OBI_ADDRW  = 32,
    parameter int  OBI_DATAW  = 32,
    parameter int  OBI_STRBW  = OBI_DATAW / 8,
    parameter type axi_req_t  = axi_2_obi_req_t,
    parameter type axi_resp_t = axi_2_obi_resp_t
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  axi_req_t             axi_req_i,
    output axi_resp_t            axi_resp_o,
    output logic [OBI_ADDRW-1:0] addr_o,
    output logic                 we_o,
    output logic [OBI_DATAW-1:0] wdata_o,
    output logic [OBI_STRBW-1:0] be_o,
    output logic                 req_o,
    input  logic                 gnt_i,
    input  logic                 rvalid_i,
    input  logic [OBI_DATAW-1:0] rdata_i
);

    axi_2_obi_state_e       r_state;
    axi_2_obi_state_e       w_state_nxt;
    logic                   r_prio_wr;     // 1: write wins a simultaneous request
    logic [AXI_ID_W-1:0]    r_id;
    logic [OBI_ADDRW-1:0]   r_addr;
    logic [7:0]             r_len;
    logic [7:0]             r_beat;
    logic [2:0]             r_size;
    logic [1:0]             r_burst;
    logic [OBI_DATAW-1:0]   r_rdata;
    logic [OBI_DATAW-1:0]   r_wdata;
    logic [OBI_STRBW-1:0]   r_wstrb;

    logic [OBI_ADDRW-1:0]   w_next_addr;
    logic                   w_idle;
    logic                   w_ar_hs;
    logic                   w_aw_hs;
    logic                   w_last;
    logic                   w_advance;
    logic                   w_unused;

    // Burst length is governed by the beat counter, so w.last is never used.
    assign w_unused = axi_req_i.w.last;

    // Readiness is suppressed during reset so no handshake can be lost.
    assign w_idle  = (r_state == IDLE) && !srst_i;
    assign w_ar_hs = w_idle && axi_req_i.ar_valid && (!axi_req_i.aw_valid || !r_prio_wr);
    assign w_aw_hs = w_idle && axi_req_i.aw_valid && (!axi_req_i.ar_valid ||  r_prio_wr);
    assign w_last  = (r_beat == r_len);

    // Step to the next beat after a read beat is consumed or a write beat completes.
    assign w_advance = !w_last &&
                       (((r_state == RD_RESP) && axi_req_i.r_ready) ||
                        ((r_state == WR_WAIT) && rvalid_i));

    axi_burst_addr_gen #(
        .ADDR_W (OBI_ADDRW)
    ) u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state   <= IDLE;
            r_prio_wr <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_rdata   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ar_hs) begin
                r_id      <= axi_req_i.ar.id;
                r_addr    <= axi_req_i.ar.addr;
                r_len     <= axi_req_i.ar.len;
                r_size    <= axi_req_i.ar.size;
                r_burst   <= axi_req_i.ar.burst;
                r_beat    <= '0;
                r_prio_wr <= ~r_prio_wr;
            end else if (w_aw_hs) begin
                r_id      <= axi_req_i.aw.id;
                r_addr    <= axi_req_i.aw.addr;
                r_len     <= axi_req_i.aw.len;
                r_size    <= axi_req_i.aw.size;
                r_burst   <= axi_req_i.aw.burst;
                r_beat    <= '0;
                r_prio_wr <= ~r_prio_wr;
            end
            if ((r_state == RD_WAIT) && rvalid_i) begin
                r_rdata <= rdata_i;
            end
            if ((r_state == WR_DATA) && axi_req_i.w_valid) begin
                r_wdata <= axi_req_i.w.data;
                r_wstrb <= axi_req_i.w.strb;
            end
            if (w_advance) begin
                r_addr <= w_next_addr;
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        axi_resp_o          = '0;
        axi_resp_o.r.id     = r_id;
        axi_resp_o.r.data   = r_rdata;
        axi_resp_o.r.resp   = RESP_OKAY;
        axi_resp_o.b.id     = r_id;
        axi_resp_o.b.resp   = RESP_OKAY;
        req_o               = 1'b0;
        we_o                = 1'b0;
        be_o                = '0;
        addr_o              = r_addr;
        wdata_o             = r_wdata;

        case (r_state)
            IDLE: begin
                axi_resp_o.ar_ready = w_ar_hs;
                axi_resp_o.aw_ready = w_aw_hs;
                if (w_ar_hs) begin
                    w_state_nxt = RD_REQ;
                end else if (w_aw_hs) begin
                    w_state_nxt = WR_DATA;
                end
            end
            RD_REQ: begin
                req_o = 1'b1;
                be_o  = '1;
                if (gnt_i) w_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (rvalid_i) w_state_nxt = RD_RESP;
            end
            RD_RESP: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r.last  = w_last;
                if (axi_req_i.r_ready) w_state_nxt = w_last ? IDLE : RD_REQ;
            end
            WR_DATA: begin
                axi_resp_o.w_ready = 1'b1;
                if (axi_req_i.w_valid) w_state_nxt = WR_REQ;
            end
            WR_REQ: begin
                req_o = 1'b1;
                we_o  = 1'b1;
                be_o  = r_wstrb;
                if (gnt_i) w_state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                if (rvalid_i) w_state_nxt = w_last ? WR_RESP : WR_DATA;
            end
            WR_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                if (axi_req_i.b_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_2_obi_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_2_obi_core
// Description : Scoreboard bench for axi_2_obi_core. Stimulus pushes expected
//               OBI requests, R beats and B responses into queues; monitors
//               pop and compare whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_2_obi_core;
    import axi_2_obi_pkg::*;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be; } obi_exp_t;
    typedef struct { logic [31:0] data; logic [3:0] id; logic last; } r_exp_t;

    logic            clk;
    logic            srst;
    axi_2_obi_req_t  stim;
    logic            rr;
    axi_2_obi_req_t  axi_req;
    axi_2_obi_resp_t axi_resp;
    logic [31:0]     addr_o;
    logic            we_o;
    logic [31:0]     wdata_o;
    logic [3:0]      be_o;
    logic            req_o;
    logic            gnt_i;
    logic            rvalid_i;
    logic [31:0]     rdata_i;

    obi_exp_t    obi_q[$];
    r_exp_t      r_q[$];
    logic [3:0]  b_q[$];
    logic [31:0] rd_data_q[$];

    int total = 0;
    int bad   = 0;
    int gnt_delay = 0;
    int stall_beat = -1;
    int stall_left = 0;
    int rbeat = 0;
    int ar_rdy_cycles = 0;
    int b_cycles = 0;

    always_comb begin
        axi_req         = stim;
        axi_req.r_ready = rr;
    end

    axi_2_obi_core u_dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .axi_req_i  (axi_req),
        .axi_resp_o (axi_resp),
        .addr_o     (addr_o),
        .we_o       (we_o),
        .wdata_o    (wdata_o),
        .be_o       (be_o),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .rvalid_i   (rvalid_i),
        .rdata_i    (rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    obi_exp_t m_o;
    r_exp_t   m_r;
    initial begin
        forever begin
            @(negedge clk);
            if (!srst) begin
                if (axi_resp.ar_ready) ar_rdy_cycles++;
                if (req_o) begin
                    if (obi_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL obi_unexpected: got addr 0x%0h expected no request", addr_o);
                    end else begin
                        m_o = obi_q[0];
                        check("obi_addr", 64'(addr_o), 64'(m_o.addr));
                        check("obi_we", 64'(we_o), 64'(m_o.we));
                        check("obi_be", 64'(be_o), 64'(m_o.be));
                        if (m_o.we) check("obi_wdata", 64'(wdata_o), 64'(m_o.wdata));
                        if (gnt_i) void'(obi_q.pop_front());
                    end
                end
                if (axi_resp.r_valid && !axi_req.r_ready)
                    check("no_req_in_r_stall", 64'(req_o), 64'(0));
                if (axi_resp.r_valid && axi_req.r_ready) begin
                    if (r_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL r_unexpected: got data 0x%0h expected no beat", axi_resp.r.data);
                    end else begin
                        m_r = r_q.pop_front();
                        check("r_data", 64'(axi_resp.r.data), 64'(m_r.data));
                        check("r_id", 64'(axi_resp.r.id), 64'(m_r.id));
                        check("r_last", 64'(axi_resp.r.last), 64'(m_r.last));
                        check("r_resp", 64'(axi_resp.r.resp), 64'(RESP_OKAY));
                    end
                end
                if (axi_resp.b_valid && axi_req.b_ready) begin
                    b_cycles++;
                    if (b_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_unexpected: got id 0x%0h expected no response", axi_resp.b.id);
                    end else begin
                        check("b_id", 64'(axi_resp.b.id), 64'(b_q.pop_front()));
                        check("b_resp", 64'(axi_resp.b.resp), 64'(RESP_OKAY));
                    end
                end
            end
        end
    end

    // OBI slave: grant after gnt_delay wait cycles, respond the cycle after.
    initial begin
        int cnt;
        logic        pend;
        logic [31:0] pend_data;
        cnt = 0; pend = 1'b0; pend_data = '0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
        forever begin
            tick();
            rvalid_i = pend;
            rdata_i  = pend_data;
            pend     = 1'b0;
            if (req_o && !srst) begin
                if (cnt >= gnt_delay) begin
                    gnt_i = 1'b1;
                    cnt   = 0;
                    pend  = 1'b1;
                    if (!we_o && rd_data_q.size() != 0) pend_data = rd_data_q.pop_front();
                    else pend_data = '0;
                end else begin
                    gnt_i = 1'b0;
                    cnt++;
                end
            end else begin
                gnt_i = 1'b0;
                cnt   = 0;
            end
        end
    end

    // R master: optional r_ready stall on one chosen beat.
    initial begin
        rr = 1'b1;
        forever begin
            tick();
            if (axi_resp.r_valid && rbeat == stall_beat && stall_left > 0) begin
                rr = 1'b0;
                stall_left--;
            end else begin
                rr = 1'b1;
            end
            @(negedge clk);
            if (axi_resp.r_valid && rr) rbeat++;
        end
    end

    task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n;
        stim.ar.addr = a; stim.ar.len = len; stim.ar.size = size;
        stim.ar.burst = burst; stim.ar.id = id; stim.ar_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (axi_resp.ar_ready) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL ar_timeout: got no ar_ready expected handshake");
                break;
            end
        end
        tick();
        stim.ar_valid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n;
        stim.aw.addr = a; stim.aw.len = len; stim.aw.size = size;
        stim.aw.burst = burst; stim.aw.id = id; stim.aw_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (axi_resp.aw_ready) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL aw_timeout: got no aw_ready expected handshake");
                break;
            end
        end
        tick();
        stim.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n;
        stim.w.data = d; stim.w.strb = s; stim.w.last = last; stim.w_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (axi_resp.w_ready) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL w_timeout: got no w_ready expected handshake");
                break;
            end
        end
        tick();
        stim.w_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((obi_q.size() + r_q.size() + b_q.size()) != 0 && n < 3000) begin
            tick();
            n++;
        end
        check(name, 64'(obi_q.size() + r_q.size() + b_q.size()), 64'(0));
        repeat (3) tick();
    endtask

    task automatic exp_obi(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] be);
        obi_exp_t e;
        e.addr = a; e.we = we; e.wdata = d; e.be = be;
        obi_q.push_back(e);
    endtask

    task automatic exp_r(input logic [31:0] d, input logic [3:0] id, input logic last);
        r_exp_t e;
        e.data = d; e.id = id; e.last = last;
        r_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, n_rd, n_wr, ord;
        stim = '0;
        stim.b_ready = 1'b1;
        srst = 1'b1;
        stim.ar_valid = 1'b1;   // ar_ready must stay low while in reset
        stim.aw_valid = 1'b1;
        repeat (3) tick();
        check("rst_resp", 64'(axi_resp), 64'(0));
        check("rst_req", 64'(req_o), 64'(0));
        check("rst_we", 64'(we_o), 64'(0));
        check("rst_addr", 64'(addr_o), 64'(0));
        check("rst_wdata", 64'(wdata_o), 64'(0));
        check("rst_be", 64'(be_o), 64'(0));
        stim.ar_valid = 1'b0;
        stim.aw_valid = 1'b0;
        tick();
        srst = 1'b0;
        tick();

        // Single read
        ar_rdy_cycles = 0;
        exp_obi(32'hAB, 1'b0, 32'h0, 4'hF);
        rd_data_q.push_back(32'h45);
        exp_r(32'h45, 4'd3, 1'b1);
        send_ar(32'hAB, 8'd0, 3'd2, BURST_INCR, 4'd3);
        wait_drain("single_read_drain");
        check("ar_ready_cycles", 64'(ar_rdy_cycles), 64'(1));

        // Single write with 3-cycle grant delay
        gnt_delay = 3;
        b_cycles = 0;
        exp_obi(32'hAB, 1'b1, 32'h69, 4'hF);
        b_q.push_back(4'd6);
        send_aw(32'hAB, 8'd0, 3'd2, BURST_INCR, 4'd6);
        send_w(32'h69, 4'hF, 1'b1);
        wait_drain("single_write_drain");
        check("b_valid_count", 64'(b_cycles), 64'(1));

        // INCR read with r_ready stall on beat 1
        gnt_delay = 0;
        rbeat = 0; stall_beat = 1; stall_left = 2;
        for (int i = 0; i < 4; i++) begin
            exp_obi(32'h100 + 32'(4 * i), 1'b0, 32'h0, 4'hF);
            rd_data_q.push_back(32'hC0DE_0000 + 32'(i));
            exp_r(32'hC0DE_0000 + 32'(i), 4'd4, (i == 3));
        end
        send_ar(32'h100, 8'd3, 3'd2, BURST_INCR, 4'd4);
        wait_drain("incr_read_drain");
        check("r_stall_applied", 64'(stall_left), 64'(0));
        stall_beat = -1;

        // FIXED write burst
        gnt_delay = 1;
        exp_obi(32'h200, 1'b1, 32'h78, 4'hF);
        exp_obi(32'h200, 1'b1, 32'hFC, 4'h3);
        exp_obi(32'h200, 1'b1, 32'h11, 4'h8);
        b_q.push_back(4'd9);
        send_aw(32'h200, 8'd2, 3'd2, BURST_FIXED, 4'd9);
        send_w(32'h78, 4'hF, 1'b0);
        send_w(32'hFC, 4'h3, 1'b0);
        send_w(32'h11, 4'h8, 1'b1);
        wait_drain("fixed_write_drain");

        // Arbitration: read, write, read. Toggle count so far is even (4 accepted).
        gnt_delay = 0;
        exp_obi(32'h40, 1'b0, 32'h0, 4'hF);
        exp_obi(32'h50, 1'b1, 32'h1234, 4'h3);
        exp_obi(32'h40, 1'b0, 32'h0, 4'hF);
        rd_data_q.push_back(32'hA1);
        rd_data_q.push_back(32'hA2);
        exp_r(32'hA1, 4'd1, 1'b1);
        exp_r(32'hA2, 4'd1, 1'b1);
        b_q.push_back(4'd2);
        stim.ar.addr = 32'h40; stim.ar.len = 8'd0; stim.ar.size = 3'd2;
        stim.ar.burst = BURST_INCR; stim.ar.id = 4'd1;
        stim.aw.addr = 32'h50; stim.aw.len = 8'd0; stim.aw.size = 3'd2;
        stim.aw.burst = BURST_INCR; stim.aw.id = 4'd2;
        stim.w.data = 32'h1234; stim.w.strb = 4'h3; stim.w.last = 1'b1;
        stim.ar_valid = 1'b1; stim.aw_valid = 1'b1; stim.w_valid = 1'b1;
        n = 0; n_rd = 0; n_wr = 0; ord = 0;
        while ((n_rd < 2 || n_wr < 1) && n < 500) begin
            @(negedge clk);
            if (axi_resp.ar_ready) begin ord = ord * 4 + 1; n_rd++; end
            if (axi_resp.aw_ready) begin ord = ord * 4 + 2; n_wr++; end
            tick();
            if (n_rd >= 2) stim.ar_valid = 1'b0;
            if (n_wr >= 1) stim.aw_valid = 1'b0;
            n++;
        end
        stim.ar_valid = 1'b0; stim.aw_valid = 1'b0;
        wait_drain("arb_drain");
        stim.w_valid = 1'b0;
        check("arb_order", 64'(ord), 64'(25));

        // Reset during beat 2 of an INCR read
        gnt_delay = 2;
        rbeat = 0;
        exp_obi(32'h300, 1'b0, 32'h0, 4'hF);
        exp_obi(32'h304, 1'b0, 32'h0, 4'hF);
        exp_obi(32'h308, 1'b0, 32'h0, 4'hF);
        rd_data_q.push_back(32'h11);
        rd_data_q.push_back(32'h22);
        rd_data_q.push_back(32'h33);
        exp_r(32'h11, 4'd5, 1'b0);
        exp_r(32'h22, 4'd5, 1'b0);
        send_ar(32'h300, 8'd3, 3'd2, BURST_INCR, 4'd5);
        n = 0;
        forever begin
            @(negedge clk);
            if (req_o && addr_o == 32'h308) break;
            n++;
            if (n > 500) begin
                total++; bad++;
                $display("FAIL beat2_timeout: got no beat-2 request expected one");
                break;
            end
        end
        tick();
        srst = 1'b1;
        tick();
        check("rst_mid_req", 64'(req_o), 64'(0));
        check("rst_mid_rvalid", 64'(axi_resp.r_valid), 64'(0));
        srst = 1'b0;
        check("rst_mid_beats_seen", 64'(r_q.size()), 64'(0));
        obi_q.delete();
        rd_data_q.delete();
        r_q.delete();
        gnt_delay = 0;
        tick();
        exp_obi(32'h10, 1'b0, 32'h0, 4'hF);
        rd_data_q.push_back(32'h5A);
        exp_r(32'h5A, 4'd7, 1'b1);
        send_ar(32'h10, 8'd0, 3'd2, BURST_INCR, 4'd7);
        wait_drain("post_reset_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
